// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcodes, FSM states, opcode classes, ALU codes.
package minisrc_pkg;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ROR  = 5'b00111;
  localparam logic [4:0] OPC_ROL  = 5'b01000;
  localparam logic [4:0] OPC_SHR  = 5'b01001;
  localparam logic [4:0] OPC_SHRA = 5'b01010;
  localparam logic [4:0] OPC_SHL  = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_DIV  = 5'b01111;
  localparam logic [4:0] OPC_MUL  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_BR   = 5'b10011;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_JAL  = 5'b10101;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_MFHI = 5'b11000;
  localparam logic [4:0] OPC_MFLO = 5'b11001;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_RESET, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU3, CL_ALU2, CL_IMM, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IO, CL_MFX, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_e;

  // Final execute step of each class; after it the FSM returns to fetch.
  function automatic state_e last_step(input op_class_e c);
    case (c)
      CL_ALU2, CL_JAL:                 return S_T4;
      CL_ALU3, CL_IMM, CL_LDI:         return S_T5;
      CL_MULDIV, CL_BR:                return S_T6;
      CL_LD, CL_ST:                    return S_T7;
      default:                         return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_op_class_decode.sv
// Combinational opcode to instruction-class decoder.
module op_class_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] opcode_i,
  output op_class_e  op_class_o
);

  // Group opcodes by the step sequence they share.
  always_comb begin
    op_class_o = CL_ILLEGAL;
    case (opcode_i)
      OPC_LD:                                   op_class_o = CL_LD;
      OPC_LDI:                                  op_class_o = CL_LDI;
      OPC_ST:                                   op_class_o = CL_ST;
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
      OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL:      op_class_o = CL_ALU3;
      OPC_ADDI, OPC_ANDI, OPC_ORI:              op_class_o = CL_IMM;
      OPC_DIV, OPC_MUL:                         op_class_o = CL_MULDIV;
      OPC_NEG, OPC_NOT:                         op_class_o = CL_ALU2;
      OPC_BR:                                   op_class_o = CL_BR;
      OPC_JR:                                   op_class_o = CL_JR;
      OPC_JAL:                                  op_class_o = CL_JAL;
      OPC_IN, OPC_OUT:                          op_class_o = CL_IO;
      OPC_MFHI, OPC_MFLO:                       op_class_o = CL_MFX;
      OPC_NOP:                                  op_class_o = CL_NOP;
      OPC_HALT:                                 op_class_o = CL_HALT;
      default:                                  op_class_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control unit: Moore FSM for fetch (F0-F2) and execute (T3-T7).
module control_unit
  import minisrc_pkg::*;
#(
  parameter bit         HALT_ON_ILLEGAL = 1'b1,
  parameter logic [4:0] ADD_OPC         = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  input  logic        Stop,
  output logic        Run,
  output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in,
  output logic        IncPC, CON_in,
  output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
  output logic        Read, Write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [4:0]  alu_instruction_bits
);

  state_e     state_q, state_d;
  logic [4:0] opc_q, opc_d;
  op_class_e  cls_ir, cls_q;
  logic       unused_ir;

  assign unused_ir = ^IR_Data[26:0];

  // The F2 exit decision (nop/illegal) needs the live IR; execute steps use the latched opcode.
  op_class_decode u_dec_ir (.opcode_i(IR_Data[31:27]), .op_class_o(cls_ir));
  op_class_decode u_dec_q  (.opcode_i(opc_q),          .op_class_o(cls_q));

  assign opc_d = (state_q == S_F2) ? IR_Data[31:27] : opc_q;

  // State and opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RESET;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Next-state: step through fetch, then execute until the class's last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2: begin
        if (cls_ir == CL_NOP || (cls_ir == CL_ILLEGAL && !HALT_ON_ILLEGAL))
          state_d = Stop ? S_HALT : S_F0;
        else if (cls_ir == CL_ILLEGAL)
          state_d = S_HALT;
        else
          state_d = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (cls_q == CL_HALT)
          state_d = S_HALT;
        else if (state_q == last_step(cls_q) || state_q == S_T7)
          state_d = Stop ? S_HALT : S_F0;
        else begin
          case (state_q)
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            default: state_d = S_T7;
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Moore outputs from state and latched class; PC_in in br T6 follows CON_out.
  always_comb begin
    Run = 1'b0;
    PC_in = 1'b0; IR_in = 1'b0; Y_in = 1'b0; Z_in = 1'b0; HI_in = 1'b0; LO_in = 1'b0;
    MAR_in = 1'b0; MDR_in = 1'b0; OutPort_in = 1'b0; IncPC = 1'b0; CON_in = 1'b0;
    PC_out = 1'b0; Zhigh_out = 1'b0; Zlow_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
    MDR_out = 1'b0; InPort_out = 1'b0; C_out = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_instruction_bits = '0;
    Run = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_F0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1; end
      S_F1: begin Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1; end
      S_F2: begin MDR_out = 1'b1; IR_in = 1'b1; end
      S_T3: begin
        case (cls_q)
          CL_ALU3, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          CL_ALU2:   begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opc_q; end
          CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
          CL_BR:     begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          CL_JR:     begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
          CL_JAL:    begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          CL_IO: begin
            if (opc_q == OPC_IN) begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            else begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
          end
          CL_MFX: begin
            Gra = 1'b1; Rin = 1'b1;
            if (opc_q == OPC_MFHI) HI_out = 1'b1;
            else LO_out = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CL_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opc_q; end
          // Immediate forms reuse the matching reg-reg ALU operation.
          CL_IMM: begin
            C_out = 1'b1; Z_in = 1'b1;
            case (opc_q)
              OPC_ANDI: alu_instruction_bits = ALU_AND;
              OPC_ORI:  alu_instruction_bits = ALU_OR;
              default:  alu_instruction_bits = ADD_OPC;
            endcase
          end
          CL_ALU2:   begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = opc_q; end
          CL_LD, CL_LDI, CL_ST: begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ADD_OPC; end
          CL_BR:     begin PC_out = 1'b1; Y_in = 1'b1; end
          CL_JAL:    begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CL_ALU3, CL_IMM, CL_LDI: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_MULDIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
          CL_LD, CL_ST: begin Zlow_out = 1'b1; MAR_in = 1'b1; end
          CL_BR:     begin C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ADD_OPC; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls_q)
          CL_MULDIV: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
          CL_LD:     begin Read = 1'b1; MDR_in = 1'b1; end
          CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
          CL_BR:     begin Zlow_out = 1'b1; PC_in = CON_out; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls_q)
          CL_LD:   begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for the Mini SRC control unit.
module tb_control_unit;

  logic        clk, clr, CON_out, Stop;
  logic [31:0] IR_Data;
  logic        Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in;
  logic        IncPC, CON_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out;
  logic        InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_instruction_bits;

  int checks = 0;
  int failures = 0;

  control_unit #(.HALT_ON_ILLEGAL(1'b1), .ADD_OPC(5'b00011)) dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .Stop(Stop), .Run(Run),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC), .CON_in(CON_in),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .alu_instruction_bits(alu_instruction_bits)
  );

  // Output bit positions in the observation vector.
  localparam logic [32:0] M_RUN   = 33'h1 << 32, M_PCIN  = 33'h1 << 31, M_IRIN  = 33'h1 << 30;
  localparam logic [32:0] M_YIN   = 33'h1 << 29, M_ZIN   = 33'h1 << 28, M_HIIN  = 33'h1 << 27;
  localparam logic [32:0] M_LOIN  = 33'h1 << 26, M_MARIN = 33'h1 << 25, M_MDRIN = 33'h1 << 24;
  localparam logic [32:0] M_OPIN  = 33'h1 << 23, M_INCPC = 33'h1 << 22, M_CONIN = 33'h1 << 21;
  localparam logic [32:0] M_PCOUT = 33'h1 << 20, M_ZHI   = 33'h1 << 19, M_ZLO   = 33'h1 << 18;
  localparam logic [32:0] M_HIOUT = 33'h1 << 17, M_LOOUT = 33'h1 << 16, M_MDROUT= 33'h1 << 15;
  localparam logic [32:0] M_INP   = 33'h1 << 14, M_COUT  = 33'h1 << 13, M_READ  = 33'h1 << 12;
  localparam logic [32:0] M_WRITE = 33'h1 << 11, M_GRA   = 33'h1 << 10, M_GRB   = 33'h1 << 9;
  localparam logic [32:0] M_GRC   = 33'h1 << 8,  M_RIN   = 33'h1 << 7,  M_ROUT  = 33'h1 << 6;
  localparam logic [32:0] M_BAOUT = 33'h1 << 5;
  localparam logic [32:0] M_ADD   = 33'h03, M_MUL = 33'h10;

  localparam logic [32:0] E_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [32:0] E_F1 = M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [32:0] E_F2 = M_RUN | M_MDROUT | M_IRIN;
  localparam logic [32:0] E_ZERO = 33'h0;

  logic [32:0] obs;
  assign obs = {Run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in,
                IncPC, CON_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
                InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
                alu_instruction_bits};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From F0: advance through F1 and F2 into the first step after fetch.
  task automatic fetch(input logic [31:0] ir);
    IR_Data = ir;
    tick();
    tick();
    tick();
  endtask

  initial begin
    clr = 1'b1; Stop = 1'b0; CON_out = 1'b0; IR_Data = '0;

    // Reset held two cycles, then fetch begins.
    tick(); chk("rst_c1", E_ZERO);
    tick(); chk("rst_c2", E_ZERO);
    clr = 1'b0;
    tick(); chk("f0_after_rst", E_F0);

    // add R5,R2,R4
    IR_Data = 32'h1A920000;
    tick(); chk("add_f1", E_F1);
    tick(); chk("add_f2", E_F2);
    tick(); chk("add_t3", M_RUN | M_GRB | M_ROUT | M_YIN);
    tick(); chk("add_t4", M_RUN | M_GRC | M_ROUT | M_ZIN | M_ADD);
    tick(); chk("add_t5", M_RUN | M_ZLO | M_GRA | M_RIN);
    tick(); chk("add_f0", E_F0);

    // brzr R6,25 not taken
    CON_out = 1'b0;
    fetch(32'h9B000019); chk("br_t3", M_RUN | M_GRA | M_ROUT | M_CONIN);
    tick(); chk("br_t4", M_RUN | M_PCOUT | M_YIN);
    tick(); chk("br_t5", M_RUN | M_COUT | M_ZIN | M_ADD);
    tick(); chk("br_t6_nt", M_RUN | M_ZLO);
    tick(); chk("br_f0", E_F0);

    // brzr R6,25 taken
    CON_out = 1'b1;
    fetch(32'h9B000019);
    tick(); tick(); tick(); chk("br_t6_tk", M_RUN | M_ZLO | M_PCIN);
    tick(); CON_out = 1'b0;

    // ld R1,0x45(R2)
    fetch(32'h00900045); chk("ld_t3", M_RUN | M_GRB | M_BAOUT | M_YIN);
    tick(); chk("ld_t4", M_RUN | M_COUT | M_ZIN | M_ADD);
    tick(); chk("ld_t5", M_RUN | M_ZLO | M_MARIN);
    tick(); chk("ld_t6", M_RUN | M_READ | M_MDRIN);
    tick(); chk("ld_t7", M_RUN | M_MDROUT | M_GRA | M_RIN);
    tick(); chk("ld_f0", E_F0);

    // st 0x87,R1: Write for exactly one cycle
    fetch(32'h10800087); chk("st_t3", M_RUN | M_GRB | M_BAOUT | M_YIN);
    tick(); tick(); chk("st_t5", M_RUN | M_ZLO | M_MARIN);
    tick(); chk("st_t6", M_RUN | M_GRA | M_ROUT | M_MDRIN);
    tick(); chk("st_t7", M_RUN | M_WRITE);
    tick(); chk("st_f0", E_F0);

    // st aborted by clr during T6
    fetch(32'h10800087);
    tick(); tick(); tick(); chk("st2_t6", M_RUN | M_GRA | M_ROUT | M_MDRIN);
    clr = 1'b1;
    tick(); chk("st2_rst", E_ZERO);
    clr = 1'b0;
    tick(); chk("st2_f0", E_F0);

    // mul R3,R4 with Stop raised mid-instruction
    fetch(32'h81A00000); chk("mul_t3", M_RUN | M_GRA | M_ROUT | M_YIN);
    tick(); chk("mul_t4", M_RUN | M_GRB | M_ROUT | M_ZIN | M_MUL);
    tick(); chk("mul_t5", M_RUN | M_ZLO | M_LOIN);
    Stop = 1'b1;
    tick(); chk("mul_t6", M_RUN | M_ZHI | M_HIIN);
    tick(); chk("mul_halt", E_ZERO);
    Stop = 1'b0;
    tick(); chk("mul_halt_hold", E_ZERO);
    clr = 1'b1; tick(); clr = 1'b0;
    tick(); chk("mul_rec_f0", E_F0);

    // halt instruction: T3 then HALT for 10 cycles
    fetch(32'hD8000000); chk("halt_t3", M_RUN);
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("halt_hold%0d", i), E_ZERO);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tick(); chk("halt_rec_f0", E_F0);

    // nop: F2 straight back to F0
    fetch(32'hD0000000); chk("nop_f0", E_F0);

    // illegal opcode halts
    fetch(32'hE0000000); chk("ill_halt", E_ZERO);
    tick(); chk("ill_hold", E_ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Mini SRC control unit: a Moore FSM that sequences the existing datapath through fetch (T0–T2) and per-opcode execute steps (T3–T7).
- Drives every bus-in, bus-out, memory and select/encode strobe that benches currently drive by hand.
- Sits beside the datapath and consumes only the IR contents and the CON flip-flop result.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 means opcodes 11100–11111 go to HALT; 0 means they execute as nop.
- ADD_OPC, 5'b00011: ALU code used for address/offset adds (ld, ldi, st, br).

Ports:
- clk input 1: system clock; all state changes on the rising edge.
- clr input 1: synchronous, active-high reset.
- IR_Data input 32: instruction register contents; opcode is IR_Data[31:27].
- CON_out input 1: branch condition result from the CON FF logic.
- Stop input 1: external halt request.
- Run output 1: high while executing; low in RESET and HALT.
- PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in output 1 each: register load enables.
- IncPC, CON_in output 1 each: ALU PC+1 select; CON FF load.
- PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out output 1 each: bus drivers.
- Read, Write output 1 each: memory strobes (Read also selects Mdatain into MDR).
- Gra, Grb, Grc, Rin, Rout, BAout output 1 each: select/encode controls.
- alu_instruction_bits output 5: ALU operation code.

Behaviour:
- One state per clock. All outputs are a pure function of the state register and the opcode captured at F2→T3.
- Outputs are 0 in any state/step not listed below; alu_instruction_bits is 0 outside ALU cycles.
- Reset: clr=1 at an edge forces RESET from any state, including mid-instruction; no memory Write completes after that edge. All outputs are 0 and Run=0 in RESET. RESET→F0 on the first edge with clr=0.
- Fetch:
  - F0: PC_out, MAR_in, IncPC, Z_in.
  - F1: Zlow_out, PC_in, Read, MDR_in.
  - F2: MDR_out, IR_in.
  - The opcode is latched from IR_Data on the F2→T3 edge.
- ALU reg-reg (add, sub, and, or, ror, rol, shr, shra, shl): T3 Grb Rout Y_in; T4 Grc Rout Z_in alu=opcode; T5 Zlow_out Gra Rin.
- neg, not: T3 Grb Rout Z_in alu=opcode; T4 Zlow_out Gra Rin.
- addi, andi, ori: as reg-reg, but T4 uses C_out instead of Grc Rout.
- mul, div: T3 Gra Rout Y_in; T4 Grb Rout Z_in alu=opcode; T5 Zlow_out LO_in; T6 Zhigh_out HI_in.
- ld: T3 Grb BAout Y_in; T4 C_out Z_in alu=ADD_OPC; T5 Zlow_out MAR_in; T6 Read MDR_in; T7 MDR_out Gra Rin.
- ldi: T3–T4 as ld; T5 Zlow_out Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDR_in (Read=0); T7 Write.
- br: T3 Gra Rout CON_in; T4 PC_out Y_in; T5 C_out Z_in alu=ADD_OPC; T6 Zlow_out, with PC_in=CON_out (not taken: PC unchanged).
- jr: T3 Gra Rout PC_in.
- jal: T3 PC_out Grb Rin (Rb field encoded 15 by assembler); T4 Gra Rout PC_in.
- Single-step ops, each in T3: in = InPort_out Gra Rin; out = Gra Rout OutPort_in; mfhi = HI_out Gra Rin; mflo = LO_out Gra Rin.
- nop: F2→F0 with no T3.
- halt: T3→HALT. HALT holds with Run=0 until clr.
- Instruction end: the last step goes to F0. If Stop=1 on that edge, go to HALT instead; Stop is ignored mid-instruction.
- Illegal opcodes: per HALT_ON_ILLEGAL.

Decomposition:
- Shared package minisrc_pkg holds:
  - opcode localparams (ld=00000 … halt=11011);
  - FSM state encoding (RESET, F0–F2, T3–T7, HALT);
  - ALU code constants.
- Sub-module op_class_decode: combinational opcode → class (ALU3, ALU2, IMM, MULDIV, LD, LDI, ST, BR, JR, JAL, IO, MFX, NOP, HALT, ILLEGAL). The FSM branches on class.

Test Plan:
- clr held 2 cycles then released → all outputs 0 and Run=0 during clr; F0 strobes (PC_out, MAR_in, IncPC, Z_in) on the next cycle.
- IR=add R5,R2,R4 (0x1A920000) → T4 alu_instruction_bits=00011 with Grc Rout; T5 Zlow_out Gra Rin; F0 on the following cycle (6 cycles total).
- brzr R6,25 with CON_out=0 → T6 Zlow_out=1, PC_in=0. Repeat with CON_out=1 → PC_in=1.
- ld R1,0x45(R2) → T6 Read=MDR_in=1; T7 MDR_out Gra Rin; Write never asserted.
- st 0x87,R1 → T7 Write=1 for exactly one cycle. Assert clr during T6 → RESET next cycle, Write never asserted.
- halt (0xD8000000) → HALT with Run=0 and all strobes 0 for 10 cycles. Stop=1 during a mul → T6 completes, then HALT.
